// File: rtl/icg_multi_hyst.sv
// Multi-channel latch-based clock gate with per-channel idle hysteresis and test enable.
// Optional all-idle cycle statistics are built when ICG_IDLE_STATS_EN is defined.
module icg_multi_hyst #(
  parameter int NCH         = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int STAT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH-1:0]    E,
  input  logic              TE,
  output logic [NCH-1:0]    Q,
  output logic [NCH-1:0]    ACTIVE,
  output logic              ALL_IDLE,
  output logic [STAT_W-1:0] IDLE_CNT
);

  localparam int CNT_W = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(IDLE_CYCLES);

  logic [CNT_W-1:0] cnt [NCH];
  logic [NCH-1:0]   en_q;
  logic [NCH-1:0]   en_next;
  logic [NCH-1:0]   latch_q;
  logic             all_idle_q;

  // A channel stays enabled while requested or while its hysteresis counter is non-zero.
  always_comb begin
    en_next = '0;
    for (int i = 0; i < NCH; i++) begin
      en_next[i] = E[i] | (cnt[i] != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
      en_q       <= '0;
      all_idle_q <= 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (E[i]) begin
          cnt[i] <= RELOAD;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
      en_q       <= en_next;
      all_idle_q <= ~|en_next;
    end
  end

  // Latch is transparent only while CLK is low, so en_q/TE changes never reach Q mid-pulse.
  always_latch begin
    if (!CLK) begin
      latch_q <= en_q | {NCH{TE}};
    end
  end

  assign Q        = {NCH{CLK}} & latch_q;
  assign ACTIVE   = en_q;
  assign ALL_IDLE = all_idle_q;

`ifdef ICG_IDLE_STATS_EN
  logic [STAT_W-1:0] idle_cnt_q;

  // Saturating count of cycles in which every channel was registered idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idle_cnt_q <= '0;
    end else if (all_idle_q && (idle_cnt_q != {STAT_W{1'b1}})) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign IDLE_CNT = idle_cnt_q;
`else
  assign IDLE_CNT = '0;
`endif

endmodule

// File: tb/tb_icg_multi_hyst.sv
// Self-checking bench for icg_multi_hyst: a default instance (IDLE_CYCLES=8) and a
// zero-hysteresis instance (IDLE_CYCLES=0, STAT_W=4) driven with the same stimulus.
module tb_icg_multi_hyst;

`ifdef ICG_IDLE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int IC_A = 8;
  localparam int IC_B = 0;
  localparam int SAT_A = 65535;
  localparam int SAT_B = 15;

  logic        CLK;
  logic        RST;
  logic [3:0]  E;
  logic        TE;
  logic [3:0]  qa, acta, qb, actb;
  logic        idle_a, idle_b;
  logic [15:0] icnt_a;
  logic [3:0]  icnt_b;

  icg_multi_hyst #(.NCH(4), .IDLE_CYCLES(IC_A), .STAT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .E(E), .TE(TE),
    .Q(qa), .ACTIVE(acta), .ALL_IDLE(idle_a), .IDLE_CNT(icnt_a)
  );

  icg_multi_hyst #(.NCH(4), .IDLE_CYCLES(IC_B), .STAT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .E(E), .TE(TE),
    .Q(qb), .ACTIVE(actb), .ALL_IDLE(idle_b), .IDLE_CNT(icnt_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nchecks = 0;
  int nerr = 0;

  task automatic chk(input string nm, input longint got, input longint want);
    nchecks++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Pulse counting and minimum-width monitor on every gated clock.
  int  pc_a [4];
  int  pc_b [4];
  int  glitches = 0;
  real rise_a [4];
  real rise_b [4];
  logic [3:0] qa_prev = '0;
  logic [3:0] qb_prev = '0;

  always @(qa or qb) begin
    for (int i = 0; i < 4; i++) begin
      if (qa[i] && !qa_prev[i]) begin
        rise_a[i] = $realtime;
        pc_a[i]++;
      end else if (!qa[i] && qa_prev[i] && ($realtime - rise_a[i] < 4.9)) begin
        glitches++;
      end
      if (qb[i] && !qb_prev[i]) begin
        rise_b[i] = $realtime;
        pc_b[i]++;
      end else if (!qb[i] && qb_prev[i] && ($realtime - rise_b[i] < 4.9)) begin
        glitches++;
      end
    end
    qa_prev = qa;
    qb_prev = qb;
  end

  // Reference model: enable follows "edges since E last sampled high <= IDLE_CYCLES".
  typedef struct {
    logic [3:0] q;
    logic [3:0] act;
    logic       idle;
    int         icnt;
  } exp_t;

  exp_t       sbq [$];
  int         last_hi [2][4];
  logic [3:0] en_m [2];
  logic       idle_m [2];
  int         icnt_m [2];
  int         k = 0;

  task automatic step(input logic rst, input logic [3:0] e, input logic te);
    exp_t x;
    exp_t ea;
    exp_t eb;
    int   ic;
    int   sat;
    logic [3:0] en_new;
    @(negedge CLK);
    RST = rst;
    E   = e;
    TE  = te;
    for (int d = 0; d < 2; d++) begin
      ic  = (d == 0) ? IC_A : IC_B;
      sat = (d == 0) ? SAT_A : SAT_B;
      x.q = en_m[d] | {4{te}};
      for (int i = 0; i < 4; i++) begin
        if (rst) begin
          last_hi[d][i] = -1000;
          en_new[i] = 1'b0;
        end else if (e[i]) begin
          last_hi[d][i] = k;
          en_new[i] = 1'b1;
        end else begin
          en_new[i] = ((k - last_hi[d][i]) <= ic);
        end
      end
      if (rst)
        icnt_m[d] = 0;
      else if (STATS && idle_m[d] && icnt_m[d] < sat)
        icnt_m[d] = icnt_m[d] + 1;
      idle_m[d] = rst ? 1'b1 : ~|en_new;
      en_m[d]   = en_new;
      x.act  = en_new;
      x.idle = idle_m[d];
      x.icnt = icnt_m[d];
      sbq.push_back(x);
    end
    k++;
    #1;
    chk("q_low_a", qa, 0);
    chk("q_low_b", qb, 0);
    @(posedge CLK);
    #1;
    ea = sbq.pop_front();
    eb = sbq.pop_front();
    chk("q_a", qa, ea.q);
    chk("act_a", acta, ea.act);
    chk("idle_a", idle_a, ea.idle);
    chk("icnt_a", icnt_a, ea.icnt);
    chk("q_b", qb, eb.q);
    chk("act_b", actb, eb.act);
    chk("idle_b", idle_b, eb.idle);
    chk("icnt_b", icnt_b, eb.icnt);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] e;
    logic       te;
    int         n;
    logic [3:0] act;
  } vec_t;

  vec_t tbl [23];

  initial begin
    int base;
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base0, base1, base3b;
    RST = 1'b1;
    E   = '0;
    TE  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en_m[d]   = '0;
      idle_m[d] = 1'b1;
      icnt_m[d] = 0;
      for (int i = 0; i < 4; i++) last_hi[d][i] = -1000;
    end

    //            rst   e      te    n   ACTIVE of dut_a after row
    tbl[0]  = '{1'b1, 4'h0, 1'b0,  2, 4'h0};
    tbl[1]  = '{1'b0, 4'h0, 1'b0, 20, 4'h0};
    tbl[2]  = '{1'b0, 4'h1, 1'b0,  3, 4'h1};
    tbl[3]  = '{1'b0, 4'h0, 1'b0,  8, 4'h1};
    tbl[4]  = '{1'b0, 4'h0, 1'b0,  1, 4'h0};
    tbl[5]  = '{1'b0, 4'h0, 1'b0,  2, 4'h0};
    tbl[6]  = '{1'b0, 4'h2, 1'b0,  1, 4'h2};
    tbl[7]  = '{1'b0, 4'h0, 1'b0,  4, 4'h2};
    tbl[8]  = '{1'b0, 4'h2, 1'b0,  1, 4'h2};
    tbl[9]  = '{1'b0, 4'h0, 1'b0,  8, 4'h2};
    tbl[10] = '{1'b0, 4'h0, 1'b0,  1, 4'h0};
    tbl[11] = '{1'b0, 4'hF, 1'b0,  2, 4'hF};
    tbl[12] = '{1'b0, 4'h5, 1'b0,  1, 4'hF};
    tbl[13] = '{1'b0, 4'h0, 1'b0,  8, 4'h5};
    tbl[14] = '{1'b0, 4'h0, 1'b0,  1, 4'h0};
    tbl[15] = '{1'b0, 4'h0, 1'b1,  4, 4'h0};
    tbl[16] = '{1'b0, 4'h0, 1'b0,  2, 4'h0};
    tbl[17] = '{1'b0, 4'h4, 1'b0,  1, 4'h4};
    tbl[18] = '{1'b0, 4'h0, 1'b0,  3, 4'h4};
    tbl[19] = '{1'b1, 4'h0, 1'b0,  1, 4'h0};
    tbl[20] = '{1'b0, 4'h0, 1'b0,  3, 4'h0};
    tbl[21] = '{1'b0, 4'h8, 1'b0,  1, 4'h8};
    tbl[22] = '{1'b0, 4'h0, 1'b0, 10, 4'h0};

    base0 = 0;
    base1 = 0;
    base3b = 0;
    for (int r = 0; r < 23; r++) begin
      if (r == 2)  base0  = pc_a[0];
      if (r == 6)  base1  = pc_a[1];
      if (r == 21) base3b = pc_b[3];
      for (int j = 0; j < tbl[r].n; j++) begin
        step(tbl[r].rst, tbl[r].e, tbl[r].te);
      end
      chk("row_act", acta, tbl[r].act);
      if (r == 1)  chk("idle_cnt_20", icnt_a, STATS ? 20 : 0);
      if (r == 5)  chk("q0_pulses", pc_a[0] - base0, 11);
      if (r == 10) chk("q1_pulses", pc_a[1] - base1, 14);
      if (r == 22) chk("q3b_pulses", pc_b[3] - base3b, 1);
    end

    // TE raised and dropped mid-cycle: Q follows only at the next low phase.
    @(negedge CLK);
    #2 TE = 1'b1;
    @(posedge CLK);
    #1 chk("te_q_on", qa, 4'hF);
    chk("te_active", acta, 0);
    chk("te_idle", idle_a, 1);
    #2 TE = 1'b0;
    #1 chk("te_hold", qa, 4'hF);
    @(posedge CLK);
    #1 chk("te_q_off", qa, 0);

    chk("sat_b", icnt_b, STATS ? 15 : 0);
    chk("glitches", glitches, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/icg_multi_hyst.md
Name: icg_multi_hyst

Overview:
- Parametrised multi-channel integrated clock gate; the next generation of the single-channel latch-based ICG with test enable.
- Each channel has a programmable idle hysteresis. After its enable drops, a channel keeps its clock running for IDLE_CYCLES cycles before gating. This stops thrashing on bursty enables.
- Sits between the root clock CLK and NCH downstream clock domains. Gating is glitch-free, using a low-transparent latch per channel.

Parameters:
- NCH, 4, number of gated clock channels (>=1).
- IDLE_CYCLES, 8, extra cycles a channel stays enabled after E[i] deasserts (>=0; 0 = no hysteresis).
- STAT_W, 16, width of the optional all-idle cycle counter.
- Derived (not overridable): CNT_W = max(1, clog2(IDLE_CYCLES+1)).

Ports:
- CLK  input  1  root clock, rising-edge active.
- RST  input  1  synchronous reset, active-high.
- E  input  NCH  per-channel functional clock request.
- TE  input  1  test enable; forces all channels on, bypassing hysteresis.
- Q  output  NCH  gated clocks.
- ACTIVE  output  NCH  registered per-channel enable state (en_q).
- ALL_IDLE  output  1  registered; 1 when every en_q is 0.
- IDLE_CNT  output  STAT_W  saturating count of ALL_IDLE cycles (see Optional Feature).

Behaviour:
- Per channel i, on each rising CLK edge, in priority order:
  - RST=1: cnt[i]<=0, en_q[i]<=0.
  - else E[i]=1: cnt[i]<=IDLE_CYCLES, en_q[i]<=1.
  - else cnt[i]!=0: cnt[i]<=cnt[i]-1, en_q[i]<=1.
  - else en_q[i]<=0.
- Gating latch per channel:
  - Transparent while CLK=0; holds while CLK=1.
  - D = en_q[i] | TE.
  - Q[i] = CLK & latch_q[i].
  - No glitch on Q for any en_q or TE change, because en_q changes only just after a rising edge while the latch holds.
- Latency:
  - E[i] sampled high at edge n gives the first Q[i] high phase at edge n+1.
  - If E[i] is last sampled high at edge m, Q[i] pulses at edges m+1 .. m+1+IDLE_CYCLES, then stays low.
- E[i] reasserting during countdown reloads cnt to IDLE_CYCLES. No Q gap, no extra latency.
- TE:
  - Combinational into the latch D input; takes effect at the next CLK-low phase.
  - Does not modify cnt or en_q.
  - ACTIVE and ALL_IDLE ignore TE.
- ALL_IDLE: registered; <= ~|en_q_next (value from the same edge update). Reset value 1.
- Reset values: en_q=0, cnt=0, ACTIVE=0, ALL_IDLE=1, IDLE_CNT=0.
  - Q=0 from the first CLK-low phase after reset is sampled, unless TE=1.
- Reset mid-countdown: cnt cleared immediately. Q stops after the current high phase completes; no truncated pulse.
- Channels are fully independent; simultaneous E changes on several channels need no arbitration.

Optional Feature:
- Macro: ICG_IDLE_STATS_EN.
- Defined:
  - IDLE_CNT increments by 1 on each rising edge where the registered ALL_IDLE=1 and RST=0.
  - Saturates at 2^STAT_W-1, no wrap.
  - Cleared by RST.
- Undefined: IDLE_CNT is tied to 0 and no counter flops are instantiated. The port list is unchanged.

Test Plan:
- Reset release, E=0, TE=0 for 20 cycles -> Q=0, ACTIVE=0, ALL_IDLE=1; IDLE_CNT=20 with macro, 0 without.
- NCH=4, IDLE_CYCLES=8; E[0] high at edges 5..7 only -> Q[0] pulses at edges 6..16 (11 pulses), then low; ACTIVE[0] falls after edge 16; other Q stay 0.
- E[1] pulses high at edge 10, then again at edge 15 (during countdown) -> Q[1] continuous from edge 11 to edge 24, no gap.
- TE=1 with all E=0 -> all Q toggle with CLK from the next low phase; ACTIVE=0, ALL_IDLE=1; TE=0 -> Q low after the current high phase.
- RST asserted mid-countdown of channel 2 (cnt=5) -> cnt=0, en_q=0 at that edge; at most the in-progress high phase completes; no glitch pulse narrower than half a CLK period.
- IDLE_CYCLES=0, STAT_W=4, macro on; E[3] single-cycle pulse -> exactly one Q[3] pulse; IDLE_CNT holds at 15 after a long idle period.
